// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that shares one UART transmitter between N_REQ byte requesters,
// holding off new grants for a full frame plus guard gap counted in baud ticks.
// States: FLUSH drain after reset | IDLE arbitrate | SEND tx_en until tick | WAIT frame+gap
module uart_tx_scheduler #(
  parameter int N_REQ       = 4,
  parameter int FRAME_TICKS = 10,
  parameter int GAP_TICKS   = 1
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     uart_tx_clk,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         ack,
  output logic                     tx_en,
  output logic [7:0]               tx_data,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);
  localparam int IW   = $clog2(N_REQ);
  localparam int HOLD = FRAME_TICKS + GAP_TICKS;
  localparam int CW   = $clog2(HOLD + 1);

  typedef enum logic [1:0] {FLUSH, IDLE, SEND, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] last;
  logic          tx_clk_q;
  logic          tick;
  logic          found;
  logic [IW-1:0] winner;
  logic [IW-1:0] cand;
  logic [7:0]    win_byte;
  logic [7:0]    bytes [N_REQ];
  int            idx;

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign bytes[g] = req_data[8*g +: 8];
  end

  assign tick = uart_tx_clk & ~tx_clk_q;
  assign busy = (state != IDLE);

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_byte = '0;
    idx      = 0;
    cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx  = (int'(last) + k) % N_REQ;
      cand = IW'(idx);
      if (!found && req[cand]) begin
        found    = 1'b1;
        winner   = cand;
        win_byte = bytes[cand];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= FLUSH;
      cnt      <= CW'(HOLD);
      tx_clk_q <= 1'b0;
      tx_en    <= 1'b0;
      tx_data  <= '0;
      ack      <= '0;
      grant_id <= '0;
      last     <= IW'(N_REQ - 1);
    end else begin
      tx_clk_q <= uart_tx_clk;
      ack      <= '0;
      case (state)
        FLUSH, WAIT: begin
          if (tick) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= IDLE;
          end
        end
        IDLE: begin
          if (found) begin
            tx_data  <= win_byte;
            tx_en    <= 1'b1;
            ack      <= N_REQ'(1) << winner;
            grant_id <= winner;
            last     <= winner;
            state    <= SEND;
          end
        end
        SEND: begin
          // A tick on the grant edge was seen in IDLE, so this is always a later one.
          if (tick) begin
            tx_en <= 1'b0;
            cnt   <= CW'(HOLD);
            state <= WAIT;
          end
        end
        default: state <= FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: grants are predicted into a queue when requests
// are driven and checked as acks appear; tick windows are counted from the driven baud clock.
module tb_uart_tx_scheduler;
  logic        sys_clk;
  logic        rst;
  logic        uart_tx_clk;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        busy;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ticks_seen = 0;

  uart_tx_scheduler #(.N_REQ(4), .FRAME_TICKS(10), .GAP_TICKS(1)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .uart_tx_clk (uart_tx_clk),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Baud clock: rises every 8 system cycles.
  initial begin
    int ph;
    ph = 7;
    uart_tx_clk = 1'b0;
    forever begin
      @(negedge sys_clk);
      ph = (ph + 1) % 8;
      uart_tx_clk = (ph < 4);
    end
  end

  // Counts the rising edges of uart_tx_clk the scheduler acts on.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(posedge sys_clk);
      if (rst === 1'b1) prev = 1'b0;
      else begin
        if (uart_tx_clk && !prev) ticks_seen++;
        prev = uart_tx_clk;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id);
    exp_t e;
    e.id   = id;
    e.data = req_data[8*id +: 8];
    sb.push_back(e);
  endtask

  // Scoreboard side: every ack must match the oldest predicted grant.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (ack !== 4'b0) begin
        if (sb.size() == 0) chk("unexpected_ack", {28'b0, ack}, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_onehot", {28'b0, ack}, 32'd1 << e.id);
          chk("tx_data", {24'b0, tx_data}, {24'b0, e.data});
          chk("grant_id", {30'b0, grant_id}, e.id);
          chk("tx_en_at_grant", {31'b0, tx_en}, 32'd1);
        end
      end
    end
  end

  task automatic wait_ack(input string tag);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge sys_clk);
      if (ack !== 4'b0) got = 1'b1;
    end
    chk({tag, "_ack_seen"}, {31'b0, got}, 32'd1);
  endtask

  // Called on the ack cycle; follows SEND and WAIT back to IDLE.
  task automatic frame(input string tag, input logic [7:0] exp_byte, input bit withdraw);
    bit en_ok, busy_ok, data_ok, ack_ok, done;
    en_ok = 1'b1; busy_ok = 1'b1; data_ok = 1'b1; ack_ok = 1'b1; done = 1'b0;
    ticks_seen = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge sys_clk);
      if (withdraw) req[3] = (ticks_seen >= 5 && ticks_seen < 10);
      if (ack !== 4'b0) ack_ok = 1'b0;
      if (tx_data !== exp_byte) data_ok = 1'b0;
      if (tx_en !== (ticks_seen == 0)) en_ok = 1'b0;
      if (ticks_seen < 12) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
      end else begin
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
        done = 1'b1;
      end
    end
    chk({tag, "_window"}, {31'b0, done}, 32'd1);
    chk({tag, "_tx_en"}, {31'b0, en_ok}, 32'd1);
    chk({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
    chk({tag, "_data_hold"}, {31'b0, data_ok}, 32'd1);
    chk({tag, "_ack_pulse"}, {31'b0, ack_ok}, 32'd1);
  endtask

  // Called on the cycle reset is released; expects exactly 11 ticks of drain.
  task automatic flush(input string tag, input logic [3:0] exp_ack);
    bit ok, done;
    ok = 1'b1; done = 1'b0;
    ticks_seen = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge sys_clk);
      if (ticks_seen < 11) begin
        if (busy !== 1'b1 || ack !== 4'b0) ok = 1'b0;
      end else begin
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
        @(negedge sys_clk);
        chk({tag, "_first_ack"}, {28'b0, ack}, {28'b0, exp_ack});
        done = 1'b1;
      end
    end
    chk({tag, "_held"}, {31'b0, ok}, 32'd1);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    bit         ok;
    int         id;

    // Reset flush with requester 0 already pending.
    req_data = 32'hC3A55A3C;
    req      = 4'b0001;
    rst      = 1'b1;
    push(0);
    repeat (3) @(negedge sys_clk);
    chk("rst_tx_en", {31'b0, tx_en}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
    chk("rst_ack", {28'b0, ack}, 32'd0);
    chk("rst_grant_id", {30'b0, grant_id}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    flush("flush", 4'b0001);
    req = 4'b0000;
    frame("flush_frame", 8'h3C, 1'b0);

    // Single byte from requester 2.
    req = 4'b0100;
    push(2);
    wait_ack("single");
    req = 4'b0000;
    frame("single", 8'hA5, 1'b0);

    // Wrap past requester 3 to 0, then 1.
    req = 4'b0011;
    push(0);
    push(1);
    wait_ack("wrap0");
    req[0] = 1'b0;
    frame("wrap0", 8'h3C, 1'b0);
    wait_ack("wrap1");
    req[1] = 1'b0;
    frame("wrap1", 8'h5A, 1'b0);

    // Requester 3 alone, leaving last=3.
    req = 4'b1000;
    push(3);
    wait_ack("solo3");
    req = 4'b0000;
    frame("solo3", 8'hC3, 1'b0);

    // All four requesting continuously; each byte changes right after its ack.
    req = 4'b1111;
    push(0); push(1); push(2); push(3);
    b = req_data[7:0] + 8'd1;
    begin
      exp_t e;
      e.id = 0; e.data = b;
      sb.push_back(e);
    end
    for (int k = 0; k < 5; k++) begin
      id = k % 4;
      wait_ack("rr");
      b = req_data[8*id +: 8];
      req_data[8*id +: 8] = b + 8'd1;
      if (k == 4) req = 4'b0000;
      frame("rr", b, 1'b0);
    end

    // Requester 3 raises and withdraws during WAIT.
    req = 4'b0010;
    push(1);
    wait_ack("withdraw");
    req = 4'b0000;
    b = req_data[15:8];
    frame("withdraw", b, 1'b1);
    ok = 1'b1;
    repeat (24) begin
      @(negedge sys_clk);
      if (ack !== 4'b0 || tx_en !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("withdraw_quiet", {31'b0, ok}, 32'd1);

    // Reset while SEND holds tx_en.
    req = 4'b0100;
    push(2);
    wait_ack("midrst");
    chk("midrst_pre_tx_en", {31'b0, tx_en}, 32'd1);
    rst = 1'b1;
    req = 4'b0001;
    push(0);
    @(negedge sys_clk);
    chk("midrst_tx_en", {31'b0, tx_en}, 32'd0);
    chk("midrst_ack", {28'b0, ack}, 32'd0);
    chk("midrst_tx_data", {24'b0, tx_data}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    flush("midrst_flush", 4'b0001);
    req = 4'b0000;
    b = req_data[7:0];
    frame("midrst_frame", b, 1'b0);

    repeat (2) @(negedge sys_clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares the single UART transmitter between several byte requesters. It sits between client logic and the transmitter, in the `sys_clk` domain, alongside the UART clock generator. It grants one requester at a time and drives the transmitter's `tx_en`/`tx_data`. It then holds off further grants for a full frame plus a guard gap, counted in baud ticks derived from `uart_tx_clk`.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `FRAME_TICKS`, 10, baud ticks per frame (start + 8 data + stop)
- `GAP_TICKS`, 1, idle baud ticks enforced between frames (≥0)

Ports:
- `sys_clk` in 1: system clock; the only clock
- `rst` in 1: synchronous, active-high reset
- `uart_tx_clk` in 1: baud clock from the clock generator, sampled as data in `sys_clk` domain
- `req` in N_REQ: per-requester byte-pending level
- `req_data` in 8*N_REQ: byte i at bits [8i+7:8i]
- `ack` out N_REQ: one-hot, 1-cycle pulse; byte i accepted
- `tx_en` out 1: start request to transmitter
- `tx_data` out 8: byte to transmitter
- `grant_id` out clog2(N_REQ): index of last granted requester
- `busy` out 1: high whenever not in IDLE

## Operation
- Tick detect: `tx_clk_q` registers `uart_tx_clk`; `tick = uart_tx_clk & ~tx_clk_q`. `tx_clk_q` resets to 0.
- States: FLUSH, IDLE, SEND, WAIT.
- FLUSH (reset state): `cnt` is loaded with FRAME_TICKS+GAP_TICKS during reset. Each tick decrements `cnt`; a tick with `cnt==1` moves to IDLE. This drains any frame cut off by reset.
- IDLE: if `req != 0`, pick the winner by round-robin, searching from `(last+1) mod N_REQ` upward with wrap. In the same edge: latch `tx_data <= byte`, `tx_en <= 1`, `ack[winner] <= 1`, `grant_id <= winner`, `last <= winner`, go to SEND. If no request, stay and change nothing.
- SEND: `ack` clears after 1 cycle. `tx_en` stays high until the first tick. On that tick: `tx_en <= 0`, `cnt <= FRAME_TICKS+GAP_TICKS`, go to WAIT.
- WAIT: each tick decrements `cnt`. A tick with `cnt==1` moves to IDLE.
- `tx_data` is held stable from grant until the next grant.
- Requester rules:
  - Hold `req` and data until `ack`.
  - Deasserting `req` before grant withdraws the request.
  - `req` still high in the cycle after `ack` is a new byte request.
  - Changes to `req` outside IDLE are only observed on IDLE entry.
- `last` resets to N_REQ-1, so requester 0 wins first after reset.
- `busy = (state != IDLE)`, combinational from the state register.

## Timing
- Reset values: `tx_en=0`, `tx_data=0`, `ack=0`, `grant_id=0`, `busy=1` (FLUSH), `cnt=FRAME_TICKS+GAP_TICKS`.
- `rst` asserted in any state, including mid-frame, returns to FLUSH on the next edge. Any `ack` or `tx_en` in flight is dropped.
- Grant latency: `req` high at edge k in IDLE gives `ack`/`tx_en` high after edge k (visible cycle k+1).
- `tx_en` width: from grant until the first tick edge, inclusive. Minimum 1 cycle if a tick coincides with the SEND entry cycle.
- The grant-to-IDLE window spans 1 + FRAME_TICKS + GAP_TICKS ticks: the SEND-exit tick plus the WAIT ticks. With defaults that is 12 ticks.
- A tick coincident with the IDLE→SEND edge is ignored; SEND waits for the next tick.
- Back-to-back: IDLE lasts ≥1 cycle between frames. Re-arbitration happens on the first IDLE edge.
- Simultaneous requests from all N_REQ requesters are served in strict rotation. Each requester waits at most N_REQ-1 frames.

## Test plan
- Reset flush: hold `rst` 3 cycles, release, toggle `uart_tx_clk` every 8 cycles with `req=0001` present. Required: `busy=1` and no `ack` until the 11th tick; `ack=0001`, `tx_data=req_data[7:0]` on the first IDLE edge afterwards.
- Single byte: `req=0100`, byte 2 = 0xA5. Required:
  - `ack=0100` for exactly 1 cycle, `tx_data=0xA5`, `grant_id=2`.
  - `tx_en` high until the first tick.
  - IDLE after exactly 11 further ticks.
- Round-robin: `req=1111` held continuously, `last=3`. Required: grant order 0,1,2,3,0, one grant per 12-tick window.
- Wrap and skip: `last=2`, `req=0011`. Required: next grant is 0, then 1; requester 3 is skipped.
- Withdraw: `req` raised during WAIT and dropped before IDLE. Required: no `ack`, `tx_en` stays 0, `busy` falls.
- Mid-frame reset: assert `rst` in SEND with `tx_en=1`. Required: next cycle `tx_en=0`, `ack=0`, `tx_data=0`, `busy=1`, and the full 11-tick flush occurs before the next grant.
